// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network readout path.
//  - dec_state_t  : decoder FSM state encoding (2 bits)
//  - DEF_*        : default network dimensions, shared with the controller
//  - idx_width()  : index width for a neuron count, never less than 1
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } dec_state_t;

    localparam int DEF_N_NEURONS    = 8;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_WINDOW       = 16;
    localparam int DEF_EARLY_THRESH = 12;

    // Window counter width; the counter stops at WINDOW so it never wraps.
    localparam int WIN_CNT_W = 16;

    // $clog2 collapses to 0 for a single neuron; an index port still needs a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_count_decoder_counter_bank.sv
// -----------------------------------------------------------------------------
// spike_counter_bank
// N_NEURONS saturating per-neuron spike counters with a single read port.
// Optional feature macro: SPIKE_DEC_EARLY_EXIT_EN (builds threshold comparators
// on the post-update counter values; otherwise thresh_hit is tied low).
// Ports:
//  clk, reset   rising-edge clock, asynchronous active-high reset
//  clear        synchronous clear of all counters (wins over inc_en)
//  inc_en       add spike_vec into the counters this cycle
//  spike_vec    one bit per neuron
//  rd_idx       neuron index for the read mux
//  rd_cnt       count of neuron rd_idx (0 for an out-of-range index)
//  thresh_hit   some counter would reach EARLY_THRESH after this update
// -----------------------------------------------------------------------------
module spike_counter_bank
    import snn_pkg::*;
#(
    parameter int N_NEURONS    = DEF_N_NEURONS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int EARLY_THRESH = DEF_EARLY_THRESH,
    localparam int IDX_W       = idx_width(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc_en,
    input  logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic                 thresh_hit
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r     [N_NEURONS];
    logic [CNT_W-1:0] cnt_nxt_s [N_NEURONS];

    // Saturating increment of every counter by its spike bit.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (spike_vec[i] && (cnt_r[i] != CNT_MAX)) begin
                cnt_nxt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Counter storage: clear has priority over accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else if (inc_en) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Read mux used by the argmax scan; guards non-power-of-two neuron counts.
    always_comb begin
        if (int'(rd_idx) < N_NEURONS) begin
            rd_cnt = cnt_r[rd_idx];
        end else begin
            rd_cnt = CNT_ZERO;
        end
    end

`ifdef SPIKE_DEC_EARLY_EXIT_EN
    // Threshold look-ahead on the values this step would write.
    always_comb begin
        thresh_hit = 1'b0;
        for (int i = 0; i < N_NEURONS; i++) begin
            thresh_hit = thresh_hit | (int'(cnt_nxt_s[i]) >= EARLY_THRESH);
        end
    end
`else
    assign thresh_hit = 1'b0;
`endif

endmodule

// File: rtl/spike_count_decoder.sv
// -----------------------------------------------------------------------------
// spike_count_decoder
// Counts output spikes per neuron over a window of valid timesteps, then scans
// the counters one neuron per cycle and reports the argmax.
// Optional feature macro: SPIKE_DEC_EARLY_EXIT_EN -- end the window as soon as
// any neuron's count reaches EARLY_THRESH (the triggering step is counted).
// Ports:
//  clk, reset    rising-edge clock, asynchronous active-high reset
//  start         begin a new window (only honoured in IDLE)
//  spike_valid   spike_in carries one timestep this cycle
//  spike_in      spike vector, one bit per output neuron
//  busy          high while accumulating or scanning
//  result_valid  one-cycle pulse when the result registers update
//  winner_idx    lowest index holding the maximum count
//  winner_count  maximum count
//  tie           another neuron shares the maximum count
// -----------------------------------------------------------------------------
module spike_count_decoder
    import snn_pkg::*;
#(
    parameter int N_NEURONS    = DEF_N_NEURONS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int WINDOW       = DEF_WINDOW,
    parameter int EARLY_THRESH = DEF_EARLY_THRESH,
    localparam int IDX_W       = idx_width(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 spike_valid,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [CNT_W-1:0]     winner_count,
    output logic                 tie
);

    localparam logic [WIN_CNT_W-1:0] WIN_LAST  = WIN_CNT_W'(WINDOW);
    localparam logic [WIN_CNT_W-1:0] WIN_ONE   = {{(WIN_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]     IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};

    dec_state_t           state_r;
    dec_state_t           state_nxt_s;
    logic [WIN_CNT_W-1:0] win_cnt_r;
    logic [IDX_W-1:0]     scan_idx_r;
    logic [IDX_W-1:0]     best_idx_r;
    logic [CNT_W-1:0]     best_cnt_r;
    logic                 best_tie_r;

    logic                 clear_s;
    logic                 inc_en_s;
    logic                 window_end_s;
    logic                 scan_last_s;
    logic [CNT_W-1:0]     rd_cnt_s;
    logic                 thresh_hit_s;
    logic [IDX_W-1:0]     cand_idx_s;
    logic [CNT_W-1:0]     cand_cnt_s;
    logic                 cand_tie_s;

    spike_counter_bank #(
        .N_NEURONS    (N_NEURONS),
        .CNT_W        (CNT_W),
        .EARLY_THRESH (EARLY_THRESH)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .inc_en     (inc_en_s),
        .spike_vec  (spike_in),
        .rd_idx     (scan_idx_r),
        .rd_cnt     (rd_cnt_s),
        .thresh_hit (thresh_hit_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (window_end_s) begin
                    state_nxt_s = ST_ARGMAX;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_ARGMAX: begin
                if (scan_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ARGMAX;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM control outputs for the counter bank, window counter and scan.
    // The last valid step counts, so the window ends on win_cnt+1 == WINDOW.
    always_comb begin
        clear_s      = 1'b0;
        inc_en_s     = 1'b0;
        window_end_s = 1'b0;
        scan_last_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = start;
            end
            ST_ACCUM: begin
                inc_en_s     = spike_valid;
                window_end_s = spike_valid &&
                               (((win_cnt_r + WIN_ONE) == WIN_LAST) || thresh_hit_s);
            end
            ST_ARGMAX: begin
                scan_last_s = (scan_idx_r == IDX_LAST);
            end
            ST_DONE: begin
                clear_s = 1'b0;
            end
            default: begin
                clear_s = 1'b0;
            end
        endcase
    end

    // Window counter: cleared on an accepted start, advanced per valid step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt_r <= {WIN_CNT_W{1'b0}};
        end else if (clear_s) begin
            win_cnt_r <= {WIN_CNT_W{1'b0}};
        end else if (inc_en_s) begin
            win_cnt_r <= win_cnt_r + WIN_ONE;
        end
    end

    // Scan index walks 0..N_NEURONS-1 in ARGMAX and rests at 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx_r <= IDX_ZERO;
        end else if ((state_r == ST_ARGMAX) && !scan_last_s) begin
            scan_idx_r <= scan_idx_r + IDX_ONE;
        end else begin
            scan_idx_r <= IDX_ZERO;
        end
    end

    // Argmax step: index 0 seeds the best entry; only a strictly greater count
    // replaces it, so the lowest index wins ties. A new maximum drops any tie.
    always_comb begin
        cand_idx_s = best_idx_r;
        cand_cnt_s = best_cnt_r;
        cand_tie_s = best_tie_r;
        if (scan_idx_r == IDX_ZERO) begin
            cand_idx_s = scan_idx_r;
            cand_cnt_s = rd_cnt_s;
            cand_tie_s = 1'b0;
        end else if (rd_cnt_s > best_cnt_r) begin
            cand_idx_s = scan_idx_r;
            cand_cnt_s = rd_cnt_s;
            cand_tie_s = 1'b0;
        end else if (rd_cnt_s == best_cnt_r) begin
            cand_tie_s = 1'b1;
        end else begin
            cand_tie_s = best_tie_r;
        end
    end

    // Running best entry, updated on every scan cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_idx_r <= IDX_ZERO;
            best_cnt_r <= CNT_ZERO;
            best_tie_r <= 1'b0;
        end else if (state_r == ST_ARGMAX) begin
            best_idx_r <= cand_idx_s;
            best_cnt_r <= cand_cnt_s;
            best_tie_r <= cand_tie_s;
        end
    end

    // Output registers. They load from the final scan step on the edge into
    // DONE, so the result is visible during the same cycle as result_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner_idx   <= IDX_ZERO;
            winner_count <= CNT_ZERO;
            tie          <= 1'b0;
        end else begin
            busy         <= (state_nxt_s == ST_ACCUM) || (state_nxt_s == ST_ARGMAX);
            result_valid <= (state_nxt_s == ST_DONE);
            if (state_nxt_s == ST_DONE) begin
                winner_idx   <= cand_idx_s;
                winner_count <= cand_cnt_s;
                tie          <= cand_tie_s;
            end
        end
    end

endmodule
